// File: rtl/chess_clock_pkg.sv
// Shared encodings and defaults for the chess clock turn controller.
package chess_clock_pkg;

  localparam int unsigned STATE_W           = 3;
  localparam int unsigned TICKS_PER_SEC_DEF = 50000;
  localparam int unsigned MOVE_W_DEF        = 8;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN_P1 = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN_P2 = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER   = 3'd4;

  // True while a player's clock is actually running.
  function automatic logic is_run(input logic [STATE_W-1:0] s);
    return (s == ST_RUN_P1) || (s == ST_RUN_P2);
  endfunction

endpackage

// File: rtl/chess_tick_gen.sv
// One-second prescaler: counts while enabled, wraps at the terminal count.
module chess_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_tc;

  assign w_at_tc  = (r_cnt == TC);
  assign o_tick_c = i_en & w_at_tc;

  // Prescaler count; clear has priority, holds when not enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/chess_turn_controller.sv
// Chess clock game FSM: turn hand-off, decrement/increment/reload pulse generation.
module chess_turn_controller
  import chess_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int unsigned MOVE_W        = MOVE_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic              p1_press,
  input  logic              p2_press,
  input  logic              p1_zero,
  input  logic              p2_zero,
  output logic              load,
  output logic              dec_p1,
  output logic              dec_p2,
  output logic              inc_p1,
  output logic              inc_p2,
  output logic              active_p2,
  output logic              running,
  output logic              flag_p1,
  output logic              flag_p2,
  output logic [MOVE_W-1:0] move_count
);

  localparam logic [MOVE_W-1:0] MC_MAX = '1;

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic               r_p1_q, r_p2_q;
  logic               w_p1_edge, w_p2_edge;
  logic               w_tick, w_cnt_en, w_cnt_clr;

  logic               r_load, r_dec_p1, r_dec_p2, r_inc_p1, r_inc_p2;
  logic               r_active_p2, r_running, r_flag_p1, r_flag_p2;
  logic [MOVE_W-1:0]  r_move_count;

  logic               w_load_nxt, w_dec_p1_nxt, w_dec_p2_nxt, w_inc_p1_nxt, w_inc_p2_nxt;
  logic               w_active_nxt, w_running_nxt, w_flag_p1_nxt, w_flag_p2_nxt;
  logic [MOVE_W-1:0]  w_mc_nxt;

  assign w_p1_edge = p1_press & ~r_p1_q;
  assign w_p2_edge = p2_press & ~r_p2_q;

  // Prescaler advances only while the game stays in the same running state.
  assign w_cnt_en  = is_run(r_state) && (w_state_nxt == r_state);
  assign w_cnt_clr = w_load_nxt | w_inc_p1_nxt | w_inc_p2_nxt;

  chess_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_cnt_en),
    .i_clr    (w_cnt_clr),
    .o_tick_c (w_tick)
  );

  // Button history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_q <= 1'b0;
      r_p2_q <= 1'b0;
    end else begin
      r_p1_q <= p1_press;
      r_p2_q <= p2_press;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: timeout beats pause beats the mover's button.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_RUN_P1;
      ST_RUN_P1: begin
        if (p1_zero)        w_state_nxt = ST_OVER;
        else if (pause)     w_state_nxt = ST_PAUSED;
        else if (w_p1_edge) w_state_nxt = ST_RUN_P2;
      end
      ST_RUN_P2: begin
        if (p2_zero)        w_state_nxt = ST_OVER;
        else if (pause)     w_state_nxt = ST_PAUSED;
        else if (w_p2_edge) w_state_nxt = ST_RUN_P1;
      end
      ST_PAUSED: if (!pause) w_state_nxt = r_active_p2 ? ST_RUN_P2 : ST_RUN_P1;
      ST_OVER:   if (start) w_state_nxt = ST_RUN_P1;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output next-values; a hand-off or timeout suppresses a coincident tick.
  always_comb begin
    w_load_nxt    = 1'b0;
    w_dec_p1_nxt  = 1'b0;
    w_dec_p2_nxt  = 1'b0;
    w_inc_p1_nxt  = 1'b0;
    w_inc_p2_nxt  = 1'b0;
    w_active_nxt  = r_active_p2;
    w_flag_p1_nxt = r_flag_p1;
    w_flag_p2_nxt = r_flag_p2;
    w_mc_nxt      = r_move_count;
    w_running_nxt = is_run(w_state_nxt);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load_nxt   = 1'b1;
          w_active_nxt = 1'b0;
        end
      end
      ST_RUN_P1: begin
        if (p1_zero) begin
          w_flag_p1_nxt = 1'b1;
        end else if (pause) begin
          w_active_nxt = 1'b0;
        end else if (w_p1_edge) begin
          w_inc_p1_nxt = 1'b1;
          w_active_nxt = 1'b1;
        end else begin
          w_dec_p1_nxt = w_tick;
        end
      end
      ST_RUN_P2: begin
        if (p2_zero) begin
          w_flag_p2_nxt = 1'b1;
        end else if (pause) begin
          w_active_nxt = 1'b1;
        end else if (w_p2_edge) begin
          w_inc_p2_nxt = 1'b1;
          w_active_nxt = 1'b0;
          w_mc_nxt     = (r_move_count == MC_MAX) ? r_move_count : r_move_count + MOVE_W'(1);
        end else begin
          w_dec_p2_nxt = w_tick;
        end
      end
      ST_OVER: begin
        if (start) begin
          w_load_nxt    = 1'b1;
          w_active_nxt  = 1'b0;
          w_flag_p1_nxt = 1'b0;
          w_flag_p2_nxt = 1'b0;
          w_mc_nxt      = '0;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load       <= 1'b0;
      r_dec_p1     <= 1'b0;
      r_dec_p2     <= 1'b0;
      r_inc_p1     <= 1'b0;
      r_inc_p2     <= 1'b0;
      r_active_p2  <= 1'b0;
      r_running    <= 1'b0;
      r_flag_p1    <= 1'b0;
      r_flag_p2    <= 1'b0;
      r_move_count <= '0;
    end else begin
      r_load       <= w_load_nxt;
      r_dec_p1     <= w_dec_p1_nxt;
      r_dec_p2     <= w_dec_p2_nxt;
      r_inc_p1     <= w_inc_p1_nxt;
      r_inc_p2     <= w_inc_p2_nxt;
      r_active_p2  <= w_active_nxt;
      r_running    <= w_running_nxt;
      r_flag_p1    <= w_flag_p1_nxt;
      r_flag_p2    <= w_flag_p2_nxt;
      r_move_count <= w_mc_nxt;
    end
  end

  assign load       = r_load;
  assign dec_p1     = r_dec_p1;
  assign dec_p2     = r_dec_p2;
  assign inc_p1     = r_inc_p1;
  assign inc_p2     = r_inc_p2;
  assign active_p2  = r_active_p2;
  assign running    = r_running;
  assign flag_p1    = r_flag_p1;
  assign flag_p2    = r_flag_p2;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Scoreboard bench for chess_turn_controller with a 10-cycle clock second.
module tb_chess_turn_controller;

  localparam int unsigned TPS = 10;
  localparam int unsigned MW  = 8;

  localparam logic [4:0] P_LOAD = 5'b10000;
  localparam logic [4:0] P_DEC1 = 5'b01000;
  localparam logic [4:0] P_DEC2 = 5'b00100;
  localparam logic [4:0] P_INC1 = 5'b00010;
  localparam logic [4:0] P_INC2 = 5'b00001;

  logic clk, reset_n, start, pause, p1_press, p2_press, p1_zero, p2_zero;
  logic load, dec_p1, dec_p2, inc_p1, inc_p2, active_p2, running, flag_p1, flag_p2;
  logic [MW-1:0] move_count;

  typedef struct {
    int          cyc;
    logic [4:0]  pulses;
    logic        run;
    logic        ap2;
    logic        f1;
    logic        f2;
    logic [MW-1:0] mc;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_err  = 0;

  chess_turn_controller #(.TICKS_PER_SEC(TPS), .MOVE_W(MW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pause      (pause),
    .p1_press   (p1_press),
    .p2_press   (p2_press),
    .p1_zero    (p1_zero),
    .p2_zero    (p2_zero),
    .load       (load),
    .dec_p1     (dec_p1),
    .dec_p2     (dec_p2),
    .inc_p1     (inc_p1),
    .inc_p2     (inc_p2),
    .active_p2  (active_p2),
    .running    (running),
    .flag_p1    (flag_p1),
    .flag_p2    (flag_p2),
    .move_count (move_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [4:0] p, input logic run, input logic ap2,
                      input logic f1, input logic f2, input logic [MW-1:0] mc);
    ev_t e;
    e.cyc = c; e.pulses = p; e.run = run; e.ap2 = ap2; e.f1 = f1; e.f2 = f2; e.mc = mc;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every pulse cycle must match the next scheduled event exactly.
  always @(negedge clk) begin
    logic [4:0] pv;
    ev_t        e;
    if (reset_n) begin
      pv = {load, dec_p1, dec_p2, inc_p1, inc_p2};
      if (pv != 5'b0) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got pulses=%b at cycle %0d, none expected", pv, cyc);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.pulses != pv || e.run !== running || e.ap2 !== active_p2 ||
              e.f1 !== flag_p1 || e.f2 !== flag_p2 || e.mc !== move_count) begin
            n_err++;
            $display("FAIL pulse_event: got cyc=%0d pulses=%b run=%b ap2=%b f1=%b f2=%b mc=%0d expected cyc=%0d pulses=%b run=%b ap2=%b f1=%b f2=%b mc=%0d",
                     cyc, pv, running, active_p2, flag_p1, flag_p2, move_count,
                     e.cyc, e.pulses, e.run, e.ap2, e.f1, e.f2, e.mc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missed_pulse: got no pulse at cycle %0d expected pulses=%b", cyc, e.pulses);
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7;
    logic [MW-1:0] mc;
    reset_n = 1'b0; start = 1'b0; pause = 1'b0;
    p1_press = 1'b0; p2_press = 1'b0; p1_zero = 1'b0; p2_zero = 1'b0;
    step(3);
    chk("reset_outputs", 32'({load, dec_p1, dec_p2, inc_p1, inc_p2, active_p2, running, flag_p1, flag_p2}), 32'd0);
    chk("reset_move_count", 32'(move_count), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Start: load, then dec_p1 every second; P2 presses ignored on P1's move
    start = 1'b1; t0 = cyc + 1; push(t0, P_LOAD, 1, 0, 0, 0, 0);
    step(1); start = 1'b0;
    push(t0 + 10, P_DEC1, 1, 0, 0, 0, 0);
    push(t0 + 20, P_DEC1, 1, 0, 0, 0, 0);
    wait_cyc(t0 + 12); p2_press = 1'b1; step(2); p2_press = 1'b0;

    // P1 ends turn with prescaler at 4; held button gives one edge only
    wait_cyc(t0 + 24); p1_press = 1'b1; t1 = t0 + 25;
    push(t1, P_INC1, 1, 1, 0, 0, 0);
    push(t1 + 10, P_DEC2, 1, 1, 0, 0, 0);
    step(4); p1_press = 1'b0;
    chk("handoff_active_p2", 32'(active_p2), 32'd1);

    // P2 ends turn: first full move
    wait_cyc(t1 + 12); p2_press = 1'b1; t2 = t1 + 13;
    push(t2, P_INC2, 1, 0, 0, 0, 1);
    step(1); p2_press = 1'b0;

    // P1 edge coincides with terminal count: increment only
    wait_cyc(t2 + 9); p1_press = 1'b1; t3 = t2 + 10;
    push(t3, P_INC1, 1, 1, 0, 0, 1);
    step(1); p1_press = 1'b0;

    // Pause 25 cycles at prescaler 3 in RUN_P2; presses and start ignored
    wait_cyc(t3 + 3); pause = 1'b1;
    wait_cyc(t3 + 10); p2_press = 1'b1; step(2); p2_press = 1'b0;
    wait_cyc(t3 + 15);
    chk("paused_running", 32'(running), 32'd0);
    chk("paused_active_p2", 32'(active_p2), 32'd1);
    wait_cyc(t3 + 28); pause = 1'b0;
    push(t3 + 36, P_DEC2, 1, 1, 0, 0, 1);
    wait_cyc(t3 + 30);
    chk("resumed_running", 32'(running), 32'd1);
    wait_cyc(t3 + 31); start = 1'b1; step(1); start = 1'b0;
    wait_cyc(t3 + 38); p2_press = 1'b1; t4 = t3 + 39;
    push(t4, P_INC2, 1, 0, 0, 0, 2);
    step(1); p2_press = 1'b0;

    // P1 timeout together with P1 edge: timeout wins
    wait_cyc(t4 + 3); p1_zero = 1'b1; p1_press = 1'b1;
    step(2); p1_press = 1'b0;
    chk("over_flag_p1", 32'(flag_p1), 32'd1);
    chk("over_flag_p2", 32'(flag_p2), 32'd0);
    chk("over_running", 32'(running), 32'd0);
    chk("over_move_count", 32'(move_count), 32'd2);
    pause = 1'b1; step(1); pause = 1'b0;
    wait_cyc(t4 + 10); start = 1'b1; p1_zero = 1'b0; t5 = t4 + 11;
    push(t5, P_LOAD, 1, 0, 0, 0, 0);
    step(1); start = 1'b0;
    chk("restart_flag_p1", 32'(flag_p1), 32'd0);

    // P2 timeout after a hand-off
    push(t5 + 10, P_DEC1, 1, 0, 0, 0, 0);
    wait_cyc(t5 + 12); p1_press = 1'b1; t6 = t5 + 13;
    push(t6, P_INC1, 1, 1, 0, 0, 0);
    step(1); p1_press = 1'b0;
    wait_cyc(t6 + 5); p2_zero = 1'b1; step(2);
    chk("p2_timeout_flag_p2", 32'(flag_p2), 32'd1);
    chk("p2_timeout_flag_p1", 32'(flag_p1), 32'd0);
    chk("p2_timeout_running", 32'(running), 32'd0);
    step(15);

    // Move counter saturation over 256 full moves
    start = 1'b1; p2_zero = 1'b0; t7 = cyc + 1;
    push(t7, P_LOAD, 1, 0, 0, 0, 0);
    step(1); start = 1'b0;
    mc = '0;
    for (int i = 0; i < 256; i++) begin
      p1_press = 1'b1; push(cyc + 1, P_INC1, 1, 1, 0, 0, mc);
      step(1); p1_press = 1'b0; step(1);
      if (mc != 8'd255) mc = mc + 8'd1;
      p2_press = 1'b1; push(cyc + 1, P_INC2, 1, 0, 0, 0, mc);
      step(1); p2_press = 1'b0; step(1);
    end
    chk("saturated_move_count", 32'(move_count), 32'd255);

    // Asynchronous reset in RUN_P2 clears outputs between clock edges
    p1_press = 1'b1; push(cyc + 1, P_INC1, 1, 1, 0, 0, 8'd255);
    step(1); p1_press = 1'b0; step(3);
    chk("pre_reset_active_p2", 32'(active_p2), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({load, dec_p1, dec_p2, inc_p1, inc_p2, active_p2, running, flag_p1, flag_p2}), 32'd0);
    chk("async_reset_move_count", 32'(move_count), 32'd0);
    step(2); reset_n = 1'b1; step(12);
    chk("post_reset_idle", 32'(running), 32'd0);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
